// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals between MEM stage, LSU and data_memory_manager.
// Latency: n/a (wires only).
// Backpressure: request side uses valid/ready; responses and memory side have none.
interface load_store_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_err_o;
    logic [31:0] resp_rdata_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_wren_o;
    logic [31:0] mem_byte_mode_o;
    logic [31:0] mem_data_i;

    // LSU side
    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  mem_data_i,
        output req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
        output mem_addr_o, mem_data_o, mem_wren_o, mem_byte_mode_o
    );

    // Pipeline + memory side
    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output mem_data_i,
        input  req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
        input  mem_addr_o, mem_data_o, mem_wren_o, mem_byte_mode_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: word-aligned memory accesses, sub-word extension on loads, RMW for sub-word stores.
// Latency: response 2 cycles after accept for word store/error, 3 for loads, 4 for sub-word stores.
// Backpressure: one request in flight (ready only in IDLE); responses are a one-cycle pulse, no stall.
module load_store_unit #(
    parameter int          MEM_ADDR_BITS  = 20,
    parameter logic [31:0] BYTE_MODE_WORD = 32'd0
) (
    input  logic              CLK,
    input  logic              RST,
    load_store_unit_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_LCAP  = 3'd2;
    localparam logic [2:0] S_MERGE = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        accept;
    logic        req_err;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Ready is forced low while reset is held even though state already sits in IDLE.
    assign accept              = bus.req_valid_i && (state_q == S_IDLE);
    assign bus.req_ready_o     = RST && (state_q == S_IDLE);
    assign bus.resp_valid_o    = resp_valid_q;
    assign bus.resp_err_o      = resp_err_q;
    assign bus.resp_rdata_o    = resp_rdata_q;
    assign bus.mem_addr_o      = mem_addr_q;
    assign bus.mem_data_o      = mem_data_q;
    assign bus.mem_wren_o      = (state_q == S_WR);
    assign bus.mem_byte_mode_o = BYTE_MODE_WORD;

    // Request legality: illegal size, misalignment, or any address bit above the decoded range.
    always_comb begin
        req_err = 1'b0;
        if (bus.req_size_i == 2'b11)                                    req_err = 1'b1;
        if (bus.req_size_i == 2'b01 && bus.req_addr_i[0])               req_err = 1'b1;
        if (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00)    req_err = 1'b1;
        if ((bus.req_addr_i >> MEM_ADDR_BITS) != 32'd0)                 req_err = 1'b1;
    end

    // Lane select and sign/zero extension of the read word for loads.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b   = bus.mem_data_i[{off_q, 3'b000} +: 8];
        lane_h   = off_q[1] ? bus.mem_data_i[31:16] : bus.mem_data_i[15:0];
        load_ext = bus.mem_data_i;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_ext = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = bus.mem_data_i;
        endcase
    end

    // Replace the addressed byte or halfword of the read word with the store data.
    always_comb begin
        merged = bus.mem_data_i;
        if (size_q == 2'b00) begin
            case (off_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // Main sequencer: next state, captured request fields, memory outputs and response pulse.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we_i;
                    size_d  = bus.req_size_i;
                    uns_d   = bus.req_unsigned_i;
                    off_d   = bus.req_addr_i[1:0];
                    wdata_d = bus.req_wdata_i[15:0];
                    if (req_err) begin
                        // Memory-side outputs are left untouched: no access for bad requests.
                        state_d = S_ERR;
                    end else begin
                        mem_addr_d = {bus.req_addr_i[31:2], 2'b00};
                        if (bus.req_we_i && bus.req_size_i == 2'b10) begin
                            mem_data_d = bus.req_wdata_i;
                            state_d    = S_WR;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD:    state_d = we_q ? S_MERGE : S_LCAP;
            S_LCAP: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_ext;
                state_d      = S_IDLE;
            end
            S_MERGE: begin
                mem_data_d = merged;
                state_d    = S_WR;
            end
            S_WR: begin
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_ERR: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= 16'd0;
            mem_addr_q   <= 32'd0;
            mem_data_q   <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests, scoreboard queue, 1-cycle-read memory model.
// Latency: responses expected at fixed offsets from the accept edge.
// Backpressure: driver waits on req_ready_o; responses are consumed unconditionally.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   wr_count = 0;
    int   wr_cyc = 0;
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_data = 32'd0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] mem [logic [31:0]];

    load_store_unit_if bus ();

    load_store_unit #(.MEM_ADDR_BITS(20), .BYTE_MODE_WORD(32'd0)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction

    // Data memory model: synchronous 1-cycle read, write on mem_wren_o.
    always @(posedge clk) begin
        bus.mem_data_i <= mem_rd(bus.mem_addr_o);
        if (bus.mem_wren_o) mem[bus.mem_addr_o] = bus.mem_data_o;
    end

    // Write observer.
    always @(negedge clk) begin
        if (bus.mem_wren_o) begin
            wr_count++;
            wr_cyc  = cyc;
            wr_addr = bus.mem_addr_o;
            wr_data = bus.mem_data_o;
        end
    end

    // Response monitor: pops the scoreboard whenever a response appears.
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid_o) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got err=%0d rdata=0x%08h expected none (cycle %0d)",
                         bus.resp_err_o, bus.resp_rdata_o, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("resp_err",   {31'd0, bus.resp_err_o}, {31'd0, e.err});
                chk("resp_rdata", bus.resp_rdata_o, e.rdata);
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    // Present one request; tn is the cycle count at the negedge preceding the accept edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd, input int lat,
                         input bit hold, output int tn);
        exp_t e;
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = a;
        bus.req_wdata_i    = wd;
        for (int i = 0; i < 50 && !bus.req_ready_o; i++) @(negedge clk);
        tn = cyc;
        if (!bus.req_ready_o) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 (addr 0x%08h)", a);
            bus.req_valid_i = 1'b0;
            return;
        end
        e.err   = e_err;
        e.rdata = e_rd;
        e.cyc   = tn + lat;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int tn, tn2, base;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'd0;
        bus.req_wdata_i    = 32'd0;
        mem[32'h0000_0104] = 32'h8899_AABB;
        mem[32'h0000_0010] = 32'h1111_1111;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready",     {31'd0, bus.req_ready_o}, 32'd0);
        chk("rst_resp_vld",  {31'd0, bus.resp_valid_o}, 32'd0);
        chk("rst_resp_err",  {31'd0, bus.resp_err_o}, 32'd0);
        chk("rst_rdata",     bus.resp_rdata_o, 32'd0);
        chk("rst_wren",      {31'd0, bus.mem_wren_o}, 32'd0);
        chk("rst_mem_addr",  bus.mem_addr_o, 32'd0);
        chk("rst_mem_data",  bus.mem_data_o, 32'd0);
        chk("byte_mode",     bus.mem_byte_mode_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", {31'd0, bus.req_ready_o}, 32'd1);

        // Sub-word loads from preloaded 0x8899AABB
        issue(1'b0, 2'b00, 1'b0, 32'h105, 32'd0, 1'b0, 32'hFFFF_FFAA, 3, 1'b0, tn); drain();
        issue(1'b0, 2'b00, 1'b1, 32'h105, 32'd0, 1'b0, 32'h0000_00AA, 3, 1'b0, tn); drain();
        issue(1'b0, 2'b01, 1'b0, 32'h106, 32'd0, 1'b0, 32'hFFFF_8899, 3, 1'b0, tn); drain();
        issue(1'b0, 2'b01, 1'b1, 32'h106, 32'd0, 1'b0, 32'h0000_8899, 3, 1'b0, tn); drain();

        // sb 0x107: read-modify-write
        base = wr_count;
        issue(1'b1, 2'b00, 1'b0, 32'h107, 32'h12, 1'b0, 32'd0, 4, 1'b0, tn); drain();
        chk("sb_wr_count", wr_count - base, 32'd1);
        chk("sb_wr_cycle", wr_cyc, tn + 3);
        chk("sb_wr_addr",  wr_addr, 32'h104);
        chk("sb_wr_data",  wr_data, 32'h1299_AABB);
        issue(1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 1'b0, 32'h1299_AABB, 3, 1'b0, tn); drain();

        // sw to bank 3
        base = wr_count;
        issue(1'b1, 2'b10, 1'b0, 32'h000C_0010, 32'hDEAD_BEEF, 1'b0, 32'd0, 2, 1'b0, tn); drain();
        chk("sw_wr_count", wr_count - base, 32'd1);
        chk("sw_wr_cycle", wr_cyc, tn + 1);
        chk("sw_wr_addr",  wr_addr, 32'h000C_0010);
        chk("sw_wr_data",  wr_data, 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h000C_0010, 32'd0, 1'b0, 32'hDEAD_BEEF, 3, 1'b0, tn); drain();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'h1111_1111, 3, 1'b0, tn); drain();

        // Error requests: no memory access
        base = wr_count;
        issue(1'b0, 2'b10, 1'b0, 32'h102,       32'd0, 1'b1, 32'd0, 2, 1'b0, tn); drain();
        issue(1'b0, 2'b01, 1'b0, 32'h101,       32'd0, 1'b1, 32'd0, 2, 1'b0, tn); drain();
        issue(1'b0, 2'b11, 1'b0, 32'h104,       32'd0, 1'b1, 32'd0, 2, 1'b0, tn); drain();
        issue(1'b0, 2'b10, 1'b0, 32'h0010_0000, 32'd0, 1'b1, 32'd0, 2, 1'b0, tn); drain();
        issue(1'b1, 2'b10, 1'b0, 32'h0010_0000, 32'h5555_5555, 1'b1, 32'd0, 2, 1'b0, tn); drain();
        chk("err_no_write", wr_count - base, 32'd0);

        // Back-to-back loads with valid held high
        issue(1'b0, 2'b00, 1'b1, 32'h104, 32'd0, 1'b0, 32'h0000_00BB, 3, 1'b1, tn);
        issue(1'b0, 2'b01, 1'b0, 32'h104, 32'd0, 1'b0, 32'hFFFF_AABB, 3, 1'b0, tn2);
        drain();
        chk("b2b_spacing", tn2 - tn, 32'd3);

        // Reset during MERGE of sb 0x104
        base = wr_count;
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = 1'b1;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'h104;
        bus.req_wdata_i    = 32'h55;
        for (int i = 0; i < 50 && !bus.req_ready_o; i++) @(negedge clk);
        chk("abort_accept_ready", {31'd0, bus.req_ready_o}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_resp_vld", {31'd0, bus.resp_valid_o}, 32'd0);
        chk("abort_wren",     {31'd0, bus.mem_wren_o}, 32'd0);
        chk("abort_mem_addr", bus.mem_addr_o, 32'd0);
        chk("abort_mem_data", bus.mem_data_o, 32'd0);
        chk("abort_rdata",    bus.resp_rdata_o, 32'd0);
        chk("abort_ready",    {31'd0, bus.req_ready_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_release", {31'd0, bus.req_ready_o}, 32'd1);
        repeat (6) @(negedge clk);
        chk("abort_no_write", wr_count - base, 32'd0);
        chk("abort_mem_word", mem_rd(32'h104), 32'h1299_AABB);
        issue(1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 1'b0, 32'h1299_AABB, 3, 1'b0, tn); drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the pipeline MEM stage and data_memory_manager.
- Takes one load or store request at a time through a valid/ready handshake.
- Issues word-aligned accesses to the data memory manager, which has a synchronous 1-cycle read and banks selected by address[19:18].
- Loads: sign/zero extension of byte and halfword data.
- Byte/halfword stores: read-modify-write.
- Misaligned or out-of-range requests are answered with an error; no memory access is made.

Parameters:
- MEM_ADDR_BITS, 20, number of decoded address bits; any request address with a bit set at or above this index is out of range.
- BYTE_MODE_WORD, 32'd0, constant driven on mem_byte_mode_o (word mode).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit can accept a request
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned_i  in  1  load zero-extends when 1
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- resp_valid_o  out  1  one-cycle response pulse
- resp_err_o  out  1  misaligned / illegal / out-of-range
- resp_rdata_o  out  32  extended load data
- mem_addr_o  out  32  {req_addr[31:2],2'b00}
- mem_data_o  out  32  write word
- mem_wren_o  out  1  write enable
- mem_byte_mode_o  out  32  always BYTE_MODE_WORD
- mem_data_i  in  32  read word; valid the cycle after mem_addr_o is presented

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE.
  - req_ready_o=0 while reset is asserted.
  - resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_wren_o=0, mem_addr_o=0, mem_data_o=0.
  - Reset asserted mid-operation aborts the operation: no write, no response.
- After reset: req_ready_o = (state==IDLE).
  - A request is accepted on the edge where req_valid_i && req_ready_o; all request fields are registered.
- Little-endian lanes. Byte offset = addr[1:0]. Halfword lane = addr[1].
- Error check at acceptance. An error is any of:
  - size==11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:MEM_ADDR_BITS]!=0
  - Response for an error: ERR state, then resp_valid_o=1, resp_err_o=1, resp_rdata_o=0 at T+2. No memory access.
- States and transitions (T = accept edge):
  - IDLE -> RD (load or sub-word store), WR (word store), ERR (error).
  - RD: mem_addr_o driven, mem_wren_o=0. -> LCAP for a load, MERGE for a store.
  - LCAP: sample mem_data_i, select lane, extend (signed unless req_unsigned_i) into resp_rdata_o. -> IDLE with resp_valid_o=1 at T+3.
  - MERGE: sample mem_data_i, replace the addressed byte or halfword with req_wdata_i[7:0] or [15:0], register the result into mem_data_o. -> WR.
  - WR: mem_wren_o=1 for exactly one cycle, mem_addr_o held. -> IDLE with resp_valid_o=1, resp_err_o=0. Response arrives at T+2 for a word store, T+4 for a sub-word store.
  - ERR: -> IDLE with the error response.
- resp_valid_o:
  - Registered; high for exactly one cycle, coinciding with the first IDLE cycle.
  - No backpressure; the consumer must take the response.
  - A new request may be accepted in that same cycle (back-to-back operation).
- Store responses return resp_rdata_o=0.
- resp_err_o is valid only when resp_valid_o=1; it is 0 otherwise.
- mem_addr_o and mem_data_o hold their last values in IDLE.
- mem_wren_o is never high outside WR.
- req_* inputs are ignored while not in IDLE.

Test Plan:
- Preload word 0x00000104=0x8899AABB.
  - lb 0x105 -> resp at T+3, rdata=0xFFFFFFAA, err=0.
  - lbu 0x105 -> 0x000000AA.
  - lh 0x106 -> 0xFFFF8899.
  - lhu 0x106 -> 0x00008899.
- sb 0x107 with wdata=0x00000012:
  - Exactly one mem_wren_o pulse at T+3, addr 0x104, data 0x1299AABB.
  - resp at T+4.
  - A following lw 0x104 returns 0x1299AABB.
- sw 0x000C0010 with 0xDEADBEEF:
  - mem_wren_o high at T+1 only, addr 0x000C0010 (bank 3), resp at T+2.
  - lw returns 0xDEADBEEF.
  - Same offset in bank 0 is unchanged.
- Each of lw 0x102, lh 0x101, size=11, and lw 0x00100000:
  - resp at T+2 with err=1, rdata=0.
  - mem_wren_o never asserted.
- Back-to-back: req_valid_i held high with two loads.
  - Second accepted in the cycle resp_valid_o=1 for the first.
  - Responses 3 cycles apart, correct data.
- RST driven low during MERGE of sb 0x104:
  - All outputs 0 immediately.
  - No write occurs; memory word unchanged.
  - No response.
  - req_ready_o=1 the first cycle after release.
